// File: rtl/multidigit_calc.sv
// Keypad calculator: decimal operand entry, W-cycle sum/shift-add/restoring-divide, 2W-cycle double-dabble.
// Define CALC_DIV_EN to build the divider (key 13); without it ERR is unreachable.
module multidigit_calc #(
    parameter int DIGITS  = 2,
    parameter int TIMEOUT = 15000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          usrin,
    output logic [8*DIGITS-1:0] disp_bcd,
    output logic [2:0]          state,
    output logic                busy,
    output logic                done,
    output logic                err
);
    // state   | meaning
    // ENTER_A | collecting first operand
    // ENTER_B | collecting second operand
    // CALC    | arithmetic, W cycles
    // CONV    | binary to BCD, 2W cycles
    // SHOW    | result on display
    // ERR     | divide by zero
    localparam int W  = $clog2(10**DIGITS);
    localparam int BW = 4*DIGITS;
    localparam int DW = 8*DIGITS;
    localparam int TW = $clog2(TIMEOUT+1);
    localparam int CW = $clog2(2*W);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0, ENTER_B = 3'd1, CALC = 3'd2, CONV = 3'd3, SHOW = 3'd4, ERR = 3'd5
    } state_t;
    typedef enum logic [1:0] {OP_MUL = 2'd0, OP_SUM = 2'd1, OP_DIV = 2'd2} op_t;

    state_t          st;
    op_t             op;
    logic [3:0]      lastkey;
    logic [TW-1:0]   idle_cnt;
    logic [W-1:0]    a, b, mq;
    logic [BW-1:0]   a_bcd, b_bcd;
    logic [2:0]      a_cnt, b_cnt;
    logic [CW-1:0]   step;
    logic [2*W-1:0]  acc, mc, bin;
    logic [DW-1:0]   bcd;

    logic            accept, is_digit, clear, op_key, div_by_zero;
    logic [3:0]      digit;
    logic [W-1:0]    a_next, b_next;
    logic [BW-1:0]   a_bcd_next, b_bcd_next;
    logic [2*W-1:0]  acc_nx, conv_in;
    logic [DW-1:0]   adj, bcd_nx;

    assign state      = st;
    assign accept     = (usrin != 4'd0) && (usrin != lastkey) && !busy;
    assign is_digit   = (usrin >= 4'd1) && (usrin <= 4'd10);
    assign clear      = accept && (usrin == 4'd14);
    assign digit      = (usrin == 4'd10) ? 4'd0 : usrin;
    assign a_next     = a * W'(10) + W'(digit);
    assign b_next     = b * W'(10) + W'(digit);
    assign a_bcd_next = BW'({a_bcd, digit});
    assign b_bcd_next = BW'({b_bcd, digit});

`ifdef CALC_DIV_EN
    localparam logic [2*W-1:0] POW10 = (2*W)'(10**DIGITS);
    logic [W:0]   rs;
    logic         qbit;
    logic [W-1:0] rem_nx;

    // acc holds {remainder, dividend/quotient}; one restoring step per cycle
    assign rs          = acc[2*W-1:W-1];
    assign qbit        = (rs >= {1'b0, b});
    assign rem_nx      = qbit ? W'(rs - {1'b0, b}) : W'(rs);
    assign op_key      = (usrin == 4'd11) || (usrin == 4'd12) || (usrin == 4'd13);
    assign div_by_zero = (op == OP_DIV) && (b == '0);
    assign conv_in     = (op == OP_DIV) ?
                         ({{W{1'b0}}, acc_nx[2*W-1:W]} * POW10 + {{W{1'b0}}, acc_nx[W-1:0]}) : acc_nx;
`else
    assign op_key      = (usrin == 4'd11) || (usrin == 4'd12);
    assign div_by_zero = 1'b0;
    assign conv_in     = acc_nx;
`endif

    always_comb begin
        acc_nx = acc;
        case (op)
            OP_MUL:  acc_nx = acc + (mq[0] ? mc : '0);
`ifdef CALC_DIV_EN
            OP_DIV:  acc_nx = {rem_nx, acc[W-2:0], qbit};
`endif
            default: acc_nx = acc;
        endcase
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 2*DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_nx = DW'({adj, bin[2*W-1]});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= ENTER_A;
            op       <= OP_MUL;
            lastkey  <= '0;
            idle_cnt <= '0;
            a        <= '0;
            b        <= '0;
            a_bcd    <= '0;
            b_bcd    <= '0;
            a_cnt    <= '0;
            b_cnt    <= '0;
            step     <= '0;
            acc      <= '0;
            mc       <= '0;
            mq       <= '0;
            bin      <= '0;
            bcd      <= '0;
            disp_bcd <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (usrin == 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT - 1)) begin
                    idle_cnt <= '0;
                    lastkey  <= 4'd0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
            if (accept) lastkey <= usrin;

            if (clear) begin
                st       <= ENTER_A;
                a        <= '0;
                b        <= '0;
                a_bcd    <= '0;
                b_bcd    <= '0;
                a_cnt    <= '0;
                b_cnt    <= '0;
                disp_bcd <= '0;
                err      <= 1'b0;
            end else begin
                case (st)
                    ENTER_A: if (accept) begin
                        if (is_digit) begin
                            if (a_cnt < 3'(DIGITS)) begin
                                a        <= a_next;
                                a_bcd    <= a_bcd_next;
                                a_cnt    <= a_cnt + 3'd1;
                                disp_bcd <= DW'(a_bcd_next);
                            end
                        end else if (op_key) begin
                            op       <= (usrin == 4'd11) ? OP_MUL : (usrin == 4'd12) ? OP_SUM : OP_DIV;
                            st       <= ENTER_B;
                            disp_bcd <= '0;
                        end
                    end
                    ENTER_B: if (accept) begin
                        if (is_digit) begin
                            if (b_cnt < 3'(DIGITS)) begin
                                b        <= b_next;
                                b_bcd    <= b_bcd_next;
                                b_cnt    <= b_cnt + 3'd1;
                                disp_bcd <= DW'(b_bcd_next);
                            end
                        end else if (usrin == 4'd15) begin
                            st   <= CALC;
                            busy <= 1'b1;
                            step <= CW'(W - 1);
                            acc  <= (op == OP_SUM) ? {{W{1'b0}}, a} + {{W{1'b0}}, b} :
                                    (op == OP_DIV) ? {{W{1'b0}}, a} : '0;
                            mc   <= {{W{1'b0}}, a};
                            mq   <= b;
                        end
                    end
                    CALC: begin
                        acc <= acc_nx;
                        mc  <= mc << 1;
                        mq  <= mq >> 1;
                        if (step == '0) begin
                            if (div_by_zero) begin
                                st       <= ERR;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                                disp_bcd <= '1;
                            end else begin
                                st   <= CONV;
                                step <= CW'(2*W - 1);
                                bin  <= conv_in;
                                bcd  <= '0;
                            end
                        end else begin
                            step <= step - CW'(1);
                        end
                    end
                    CONV: begin
                        bcd <= bcd_nx;
                        bin <= bin << 1;
                        if (step == '0) begin
                            st       <= SHOW;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            disp_bcd <= bcd_nx;
                        end else begin
                            step <= step - CW'(1);
                        end
                    end
                    SHOW: if (accept && is_digit) begin
                        a        <= W'(digit);
                        a_bcd    <= BW'(digit);
                        a_cnt    <= 3'd1;
                        b        <= '0;
                        b_bcd    <= '0;
                        b_cnt    <= '0;
                        st       <= ENTER_A;
                        disp_bcd <= DW'(digit);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multidigit_calc.sv
// Directed bench for multidigit_calc with DIGITS=2, TIMEOUT=4 (W=7, result after 21 cycles).
module tb_multidigit_calc;
    logic        clk;
    logic        rst;
    logic [3:0]  usrin;
    logic [15:0] disp_bcd;
    logic [2:0]  state;
    logic        busy, done, err;
    int          checks = 0;
    int          errors = 0;

    multidigit_calc #(.DIGITS(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .usrin(usrin), .disp_bcd(disp_bcd),
        .state(state), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic [3:0] k);
        usrin = k;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        cyc(k);
        repeat (4) cyc(4'd0);
    endtask

    task automatic test_reset;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL reset_disp: got %h expected 0000", disp_bcd); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err}); end
    endtask

    task automatic test_mul;
        press(4'd1);
        checks++; if (disp_bcd !== 16'h0001) begin errors++; $display("FAIL mul_a1: got %h expected 0001", disp_bcd); end
        press(4'd2);
        checks++; if (disp_bcd !== 16'h0012) begin errors++; $display("FAIL mul_a12: got %h expected 0012", disp_bcd); end
        press(4'd11);
        checks++; if (state !== 3'd1 || disp_bcd !== 16'h0000) begin errors++; $display("FAIL mul_op: got state %0d disp %h expected 1 0000", state, disp_bcd); end
        press(4'd3);
        press(4'd4);
        checks++; if (disp_bcd !== 16'h0034) begin errors++; $display("FAIL mul_b34: got %h expected 0034", disp_bcd); end
        cyc(4'd15);
        checks++; if (state !== 3'd2 || busy !== 1'b1 || disp_bcd !== 16'h0034) begin errors++; $display("FAIL mul_calc: got state %0d busy %b disp %h expected 2 1 0034", state, busy, disp_bcd); end
        repeat (7) cyc(4'd0);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL mul_conv_entry: got %0d expected 3", state); end
        repeat (13) cyc(4'd0);
        checks++; if (state !== 3'd3 || done !== 1'b0) begin errors++; $display("FAIL mul_cycle20: got state %0d done %b expected 3 0", state, done); end
        cyc(4'd0);
        checks++; if (state !== 3'd4 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mul_cycle21: got state %0d done %b busy %b expected 4 1 0", state, done, busy); end
        checks++; if (disp_bcd !== 16'h0408) begin errors++; $display("FAIL mul_result: got %h expected 0408", disp_bcd); end
        cyc(4'd0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_repeat_keys;
        cyc(4'd9);
        checks++; if (state !== 3'd0 || disp_bcd !== 16'h0009) begin errors++; $display("FAIL rep_new_entry: got state %0d disp %h expected 0 0009", state, disp_bcd); end
        repeat (4) cyc(4'd0);
        cyc(4'd9);
        cyc(4'd11);
        cyc(4'd9);
        cyc(4'd9);
        checks++; if (disp_bcd !== 16'h0009) begin errors++; $display("FAIL rep_held_key: got %h expected 0009", disp_bcd); end
        repeat (4) cyc(4'd0);
        cyc(4'd9);
        checks++; if (disp_bcd !== 16'h0099) begin errors++; $display("FAIL rep_b99: got %h expected 0099", disp_bcd); end
        cyc(4'd15);
        repeat (21) cyc(4'd0);
        checks++; if (state !== 3'd4 || disp_bcd !== 16'h9801) begin errors++; $display("FAIL rep_result: got state %0d disp %h expected 4 9801", state, disp_bcd); end
    endtask

`ifdef CALC_DIV_EN
    task automatic test_div;
        press(4'd5);
        press(4'd7);
        press(4'd13);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL div_op: got %0d expected 1", state); end
        press(4'd8);
        cyc(4'd15);
        repeat (21) cyc(4'd0);
        checks++; if (state !== 3'd4 || disp_bcd !== 16'h0107) begin errors++; $display("FAIL div_result: got state %0d disp %h expected 4 0107", state, disp_bcd); end
    endtask

    task automatic test_div_zero;
        press(4'd5);
        press(4'd13);
        press(4'd10);
        cyc(4'd15);
        repeat (6) cyc(4'd0);
        checks++; if (state !== 3'd2 || err !== 1'b0) begin errors++; $display("FAIL divz_cycle6: got state %0d err %b expected 2 0", state, err); end
        cyc(4'd0);
        checks++; if (state !== 3'd5 || err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL divz_err: got state %0d err %b busy %b expected 5 1 0", state, err, busy); end
        checks++; if (disp_bcd !== 16'hFFFF) begin errors++; $display("FAIL divz_disp: got %h expected ffff", disp_bcd); end
        press(4'd14);
        checks++; if (state !== 3'd0 || disp_bcd !== 16'h0000 || err !== 1'b0) begin errors++; $display("FAIL divz_clear: got state %0d disp %h err %b expected 0 0000 0", state, disp_bcd, err); end
    endtask
`else
    task automatic test_no_div;
        press(4'd14);
        checks++; if (state !== 3'd0 || disp_bcd !== 16'h0000) begin errors++; $display("FAIL nodiv_clear: got state %0d disp %h expected 0 0000", state, disp_bcd); end
        press(4'd5);
        press(4'd13);
        checks++; if (state !== 3'd0 || disp_bcd !== 16'h0005) begin errors++; $display("FAIL nodiv_key13: got state %0d disp %h expected 0 0005", state, disp_bcd); end
        press(4'd12);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL nodiv_sum_key: got %0d expected 1", state); end
        press(4'd14);
        checks++; if (state !== 3'd0 || disp_bcd !== 16'h0000) begin errors++; $display("FAIL nodiv_clear2: got state %0d disp %h expected 0 0000", state, disp_bcd); end
    endtask
`endif

    task automatic test_hold_timeout;
        repeat (10) cyc(4'd3);
        repeat (2) cyc(4'd0);
        repeat (3) cyc(4'd3);
        checks++; if (state !== 3'd0 || disp_bcd !== 16'h0003) begin errors++; $display("FAIL hold_single: got state %0d disp %h expected 0 0003", state, disp_bcd); end
        repeat (3) cyc(4'd0);
        cyc(4'd3);
        checks++; if (disp_bcd !== 16'h0003) begin errors++; $display("FAIL hold_3zeros: got %h expected 0003", disp_bcd); end
        repeat (4) cyc(4'd0);
        cyc(4'd3);
        checks++; if (disp_bcd !== 16'h0033) begin errors++; $display("FAIL hold_4zeros: got %h expected 0033", disp_bcd); end
        repeat (4) cyc(4'd0);
        cyc(4'd5);
        checks++; if (disp_bcd !== 16'h0033) begin errors++; $display("FAIL digit_limit: got %h expected 0033", disp_bcd); end
    endtask

    task automatic test_busy_and_reset;
        repeat (4) cyc(4'd0);
        press(4'd11);
        press(4'd2);
        cyc(4'd15);
        cyc(4'd14);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL busy_ignores_clear: got %0d expected 2", state); end
        repeat (9) cyc(4'd0);
        checks++; if (state !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset_conv: got state %0d busy %b expected 3 1", state, busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", state); end
        checks++; if ({disp_bcd, busy, done, err} !== 19'd0) begin errors++; $display("FAIL async_reset_outs: got disp %h flags %b expected 0000 000", disp_bcd, {busy, done, err}); end
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (state !== 3'd0 || disp_bcd !== 16'h0000) begin errors++; $display("FAIL post_reset: got state %0d disp %h expected 0 0000", state, disp_bcd); end
    endtask

    initial begin
        rst   = 1'b0;
        usrin = 4'd0;
        #12;
        test_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_mul;
        test_repeat_keys;
`ifdef CALC_DIV_EN
        test_div;
        test_div_zero;
`else
        test_no_div;
`endif
        test_hold_timeout;
        test_busy_and_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multidigit_calc.md
MULTIDIGIT_CALC -- requirements
Module: multidigit_calc

Interface
REQ-001 Parameter DIGITS, default 2: decimal digits per operand, range 1..4.
REQ-002 Parameter TIMEOUT, default 15000000: consecutive usrin==0 cycles that release the key memory.
REQ-003 Derived W = ceil(log2(10^DIGITS)) is the operand binary width; the result register is 2W bits.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  asynchronous active-low reset.
REQ-006 Port usrin  input  4  keypad code: 0 none, 1-9 digit, 10 digit zero, 11 MUL, 12 SUM, 13 DIV, 14 CLEAR, 15 EQUALS.
REQ-007 Port disp_bcd  output  8*DIGITS  2*DIGITS packed BCD digits for display, least significant digit in bits [3:0].
REQ-008 Port state  output  3  current FSM state encoding.
REQ-009 Port busy  output  1  high in CALC and CONV.
REQ-010 Port done  output  1  one-cycle pulse on entry to SHOW.
REQ-011 Port err  output  1  high while in ERR.

Function
REQ-012 FSM states and encodings SHALL be ENTER_A=0, ENTER_B=1, CALC=2, CONV=3, SHOW=4, ERR=5.
REQ-013 A key is accepted only when usrin!=0 and usrin!=lastkey; on acceptance lastkey<=usrin.
REQ-014 A counter SHALL count consecutive usrin==0 cycles; at TIMEOUT, lastkey<=0 and the counter clears; any nonzero usrin clears the counter.
REQ-015 A digit accepted in ENTER_A/ENTER_B does operand<=operand*10+digit while fewer than DIGITS digits have been entered; further digits are recorded in lastkey but do not change the operand.
REQ-016 In ENTER_A, key 11/12/13 latches op and moves to ENTER_B; 15 is ignored.
REQ-017 In ENTER_B, operator keys are ignored; 15 moves to CALC.
REQ-018 CALC SHALL last exactly W cycles for every op: SUM adds; MUL is shift-add; DIV is restoring shift-subtract producing quotient and remainder.
REQ-019 DIV with B==0 SHALL go from CALC to ERR after the W cycles, without entering CONV.
REQ-020 CONV SHALL be a sequential double-dabble of exactly 2W cycles; SHOW is entered 3W cycles after the equals-accept edge.
REQ-021 In DIV, the low DIGITS BCD digits are the quotient and the high DIGITS digits are the remainder.
REQ-022 disp_bcd shows A in ENTER_A, B in ENTER_B, the result in SHOW, all 0xF digits in ERR, and holds its last value in CALC/CONV.
REQ-023 Keys are neither accepted nor recorded in lastkey while busy.
REQ-024 CLEAR (14) accepted in ENTER_A, ENTER_B, SHOW or ERR zeroes the operands and digit counts and moves to ENTER_A.
REQ-025 In SHOW, an accepted digit starts a new entry: A<=digit and state<=ENTER_A.

Reset
REQ-026 rst low SHALL immediately set state=ENTER_A, operands/result/lastkey/timeout counter=0, disp_bcd=0, busy=0, done=0, err=0, including mid-CALC/CONV.

Configuration
REQ-027 With CALC_DIV_EN defined, DIV is implemented per REQ-018/019/021.
REQ-028 Without CALC_DIV_EN, the divider is absent, key 13 is ignored in ENTER_A, and ERR is unreachable.

Verification (DIGITS=2, TIMEOUT=4)
REQ-029 Keys 1,2,11,3,4,15, each followed by 4 zero cycles -> done after 21 cycles, disp_bcd=0x0408.
REQ-030 Keys 9,(4 zero cycles),9,11,9,(zeros),9,15 -> disp_bcd=0x9801.
REQ-031 Keys 5,7,13,8,15 with CALC_DIV_EN -> disp_bcd=0x0107 (remainder 01, quotient 07).
REQ-032 Keys 5,13,10,15 -> err=1 after 7 cycles, disp_bcd=0xFFFF; then CLEAR -> ENTER_A, disp_bcd=0.
REQ-033 usrin held at 3 for 10 cycles, then 0 for 2 cycles, then 3 again -> A=3 (single digit accepted).
REQ-034 rst pulsed low during CONV -> all outputs 0 within the same cycle; state=ENTER_A.
